ram_rr_arbiter: RTL and testbench

- Shares the single-port 32x32 synchronous RAM (ports clk, ena, wena, addr, data_in, data_out) between two independent requesters, A and B.
- Arbitration is two-way round-robin, one access per cycle, with a registered read-valid return path.
- Contains a clear engine that, on command, writes CLR_VALUE to every word and blocks requesters while it runs.
- Sits between the client logic and the RAM instance; it is the only block that drives the RAM control ports.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 21 ++
 rtl/ram_rr_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_rr_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package ram_arb_pkg;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 32;
    localparam logic [31:0] CLR_VALUE = 32'h0000_0000;

    // Requester ids, also used as bit positions in the req/gnt vectors
    // and as the value held by the last-grant pointer.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Stateless two-way round-robin grant: on a tie the requester that was not
// granted last wins. The last-grant pointer is held by the parent.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Single winner; A wins a tie only when B was the last one served.
    always_comb begin
        gnt = 2'b00;
        if (req[REQ_A] && (!req[REQ_B] || (last == REQ_B))) begin
            gnt[REQ_A] = 1'b1;
        end else if (req[REQ_B]) begin
            gnt[REQ_B] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one single-port synchronous RAM between requesters A and B with
// round-robin arbitration, a one-cycle read return and a full-memory clear.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   SERVE | arbitrate A/B, one RAM access per cycle; clr moves to CLEAR
//   CLEAR | write CLR_VALUE to address clr_cnt, requesters blocked, busy=1
module ram_rr_arbiter #(
    parameter int AW = ram_arb_pkg::AW,
    parameter int DW = ram_arb_pkg::DW,
    parameter int DEPTH = ram_arb_pkg::DEPTH,
    parameter logic [DW-1:0] CLR_VALUE = DW'(ram_arb_pkg::CLR_VALUE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          busy,

    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,

    output logic          ram_ena,
    output logic          ram_wena,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    import ram_arb_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] clr_cnt;
    logic          last;
    logic [1:0]    arb_gnt;

    rr_arb2 u_rr_arb2 (
        .req  ({b_req, a_req}),
        .last (last),
        .gnt  (arb_gnt)
    );

    // The RAM output register already holds the word one cycle after the
    // read; both owners see it and rvalid tells them whose it is.
    assign a_rdata = ram_dout;
    assign b_rdata = ram_dout;

    // Next state, grants and RAM drive; clr beats any pending request.
    always_comb begin
        next_state = state;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        busy       = 1'b0;
        ram_ena    = 1'b0;
        ram_wena   = 1'b0;
        ram_addr   = '0;
        ram_din    = '0;
        case (state)
            SERVE: begin
                if (!rst) begin
                    if (clr) begin
                        next_state = CLEAR;
                    end else begin
                        a_gnt = arb_gnt[REQ_A];
                        b_gnt = arb_gnt[REQ_B];
                        if (arb_gnt[REQ_A]) begin
                            ram_ena  = 1'b1;
                            ram_wena = a_we;
                            ram_addr = a_addr;
                            ram_din  = a_wdata;
                        end else if (arb_gnt[REQ_B]) begin
                            ram_ena  = 1'b1;
                            ram_wena = b_we;
                            ram_addr = b_addr;
                            ram_din  = b_wdata;
                        end
                    end
                end
            end
            CLEAR: begin
                busy     = 1'b1;
                ram_ena  = !rst;
                ram_wena = 1'b1;
                ram_addr = clr_cnt;
                ram_din  = CLR_VALUE;
                if (clr_cnt == LAST_ADDR) begin
                    next_state = SERVE;
                end
            end
            default: begin
                next_state = SERVE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SERVE;
        end else begin
            state <= next_state;
        end
    end

    // Clear address counter: steps once per CLEAR cycle, parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= '0;
        end else if (state == CLEAR) begin
            if (clr_cnt == LAST_ADDR) begin
                clr_cnt <= '0;
            end else begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Last-grant pointer; starts at B so A wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= REQ_B;
        end else if (a_gnt) begin
            last <= REQ_A;
        end else if (b_gnt) begin
            last <= REQ_B;
        end
    end

    // Read-valid return, aligned with the RAM output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= a_gnt && !a_we;
            b_rvalid <= b_gnt && !b_we;
        end
    end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Bench for ram_rr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_ram_rr_arbiter;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        busy;
    logic        a_req, a_we, a_gnt, a_rvalid;
    logic [4:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        b_req, b_we, b_gnt, b_rvalid;
    logic [4:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic        ram_ena, ram_wena;
    logic [4:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;

    ram_rr_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .ram_ena  (ram_ena),
        .ram_wena (ram_wena),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    // Single-port synchronous RAM the arbiter drives.
    logic [31:0] ram_mem [32];
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wena) ram_mem[ram_addr] <= ram_din;
            else          ram_dout <= ram_mem[ram_addr];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: memory image, clear progress, who was served last,
    // and the read result owed to each requester in the coming cycle.
    logic [31:0] m_mem [32];
    bit          m_clearing;
    int          m_cnt;
    int          m_last;          // 0 = A, 1 = B
    bit          exp_a_rv, exp_b_rv;
    logic [31:0] exp_a_data, exp_b_data;

    bit          obs_a_gnt, obs_b_gnt, obs_a_rv, obs_b_rv, obs_busy;
    logic [31:0] obs_a_rdata, obs_b_rdata;

    task automatic set_a(input bit req, input bit we, input int addr, input logic [31:0] data);
        a_req = req; a_we = we; a_addr = 5'(addr); a_wdata = data;
    endtask

    task automatic set_b(input bit req, input bit we, input int addr, input logic [31:0] data);
        b_req = req; b_we = we; b_addr = 5'(addr); b_wdata = data;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic run_cycle();
        bit eg_a, eg_b, e_ena;
        @(negedge clk);
        eg_a = 1'b0;
        eg_b = 1'b0;
        if (!rst && !m_clearing && !clr) begin
            if (a_req && b_req) begin
                eg_a = (m_last == 1);
                eg_b = (m_last == 0);
            end else begin
                eg_a = a_req;
                eg_b = b_req;
            end
        end
        e_ena = !rst && (m_clearing || eg_a || eg_b);
        chk("a_gnt", 32'(a_gnt), 32'(eg_a));
        chk("b_gnt", 32'(b_gnt), 32'(eg_b));
        chk("busy", 32'(busy), 32'(m_clearing));
        chk("a_rvalid", 32'(a_rvalid), 32'(exp_a_rv));
        chk("b_rvalid", 32'(b_rvalid), 32'(exp_b_rv));
        if (exp_a_rv) chk("a_rdata", a_rdata, exp_a_data);
        if (exp_b_rv) chk("b_rdata", b_rdata, exp_b_data);
        chk("ram_ena", 32'(ram_ena), 32'(e_ena));
        if (e_ena) begin
            if (m_clearing) begin
                chk("ram_wena", 32'(ram_wena), 32'd1);
                chk("ram_addr", 32'(ram_addr), 32'(m_cnt));
                chk("ram_din", ram_din, 32'h0);
            end else if (eg_a) begin
                chk("ram_wena", 32'(ram_wena), 32'(a_we));
                chk("ram_addr", 32'(ram_addr), 32'(a_addr));
                chk("ram_din", ram_din, a_wdata);
            end else begin
                chk("ram_wena", 32'(ram_wena), 32'(b_we));
                chk("ram_addr", 32'(ram_addr), 32'(b_addr));
                chk("ram_din", ram_din, b_wdata);
            end
        end else if (!m_clearing) begin
            chk("idle_wena", 32'(ram_wena), 32'd0);
            chk("idle_addr", 32'(ram_addr), 32'd0);
            chk("idle_din", ram_din, 32'h0);
        end
        obs_a_gnt = a_gnt;
        obs_b_gnt = b_gnt;
        obs_a_rv = a_rvalid;
        obs_b_rv = b_rvalid;
        obs_busy = busy;
        obs_a_rdata = a_rdata;
        obs_b_rdata = b_rdata;

        @(posedge clk);
        exp_a_rv = 1'b0;
        exp_b_rv = 1'b0;
        if (rst) begin
            m_clearing = 1'b0;
            m_cnt = 0;
            m_last = 1;
        end else if (m_clearing) begin
            m_mem[m_cnt] = 32'h0;
            m_cnt++;
            if (m_cnt == 32) begin
                m_clearing = 1'b0;
                m_cnt = 0;
            end
        end else if (clr) begin
            m_clearing = 1'b1;
            m_cnt = 0;
        end else begin
            if (eg_a) begin
                if (a_we) m_mem[a_addr] = a_wdata;
                else begin exp_a_rv = 1'b1; exp_a_data = m_mem[a_addr]; end
                m_last = 0;
            end
            if (eg_b) begin
                if (b_we) m_mem[b_addr] = b_wdata;
                else begin exp_b_rv = 1'b1; exp_b_data = m_mem[b_addr]; end
                m_last = 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        clr = 1'b0;
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
    endtask

    task automatic fill_a();
        for (int i = 0; i < 32; i++) begin
            set_a(1, 1, i, 32'(i + 1));
            run_cycle();
            chk("fill_gnt", 32'(obs_a_gnt), 32'd1);
        end
        set_a(0, 0, 0, 0);
    endtask

    task automatic count_clear(input string tag);
        int busy_cnt;
        int gnt_busy;
        busy_cnt = 0;
        gnt_busy = 0;
        for (int i = 0; i < 40; i++) begin
            run_cycle();
            if (obs_busy) begin
                busy_cnt++;
                if (obs_a_gnt || obs_b_gnt) gnt_busy++;
            end
        end
        chk({tag, "_len"}, 32'(busy_cnt), 32'd32);
        chk({tag, "_gnt"}, 32'(gnt_busy), 32'd0);
    endtask

    task automatic read_a(input string tag, input int addr, input logic [31:0] exp);
        set_a(1, 0, addr, 32'h0);
        run_cycle();
        set_a(0, 0, 0, 0);
        run_cycle();
        chk({tag, "_rv"}, 32'(obs_a_rv), 32'd1);
        chk({tag, "_data"}, obs_a_rdata, exp);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram_mem[i] = 32'h0;
            m_mem[i] = 32'h0;
        end
        ram_dout = 32'h0;
        m_clearing = 1'b0;
        m_cnt = 0;
        m_last = 1;
        exp_a_rv = 1'b0;
        exp_b_rv = 1'b0;
        exp_a_data = 32'h0;
        exp_b_data = 32'h0;
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        clr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, checked while rst is still high.
        set_a(1, 0, 1, 0);
        set_b(1, 0, 2, 0);
        run_cycle();
        chk("rst_a_gnt", 32'(obs_a_gnt), 32'd0);
        chk("rst_busy", 32'(obs_busy), 32'd0);
        do_reset();

        // Single write then read by A.
        set_a(1, 1, 5, 32'hDEAD_BEEF);
        run_cycle();
        chk("wr_gnt", 32'(obs_a_gnt), 32'd1);
        set_a(1, 0, 5, 32'h0);
        run_cycle();
        chk("rd_gnt", 32'(obs_a_gnt), 32'd1);
        set_a(0, 0, 0, 0);
        run_cycle();
        chk("rd_rv", 32'(obs_a_rv), 32'd1);
        chk("rd_data", obs_a_rdata, 32'hDEAD_BEEF);
        chk("rd_b_rv", 32'(obs_b_rv), 32'd0);

        // Fairness: both hold reads for six cycles after a reset.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_a(1, 0, $urandom_range(0, 31), 32'h0);
            set_b(1, 0, $urandom_range(0, 31), 32'h0);
            run_cycle();
            chk("fair_a", 32'(obs_a_gnt), 32'(i % 2 == 0));
            chk("fair_b", 32'(obs_b_gnt), 32'(i % 2 == 1));
        end
        set_a(0, 0, 0, 0);
        set_b(0, 0, 0, 0);
        run_cycle();

        // Concurrent writes, then concurrent reads back to the right owner.
        do_reset();
        set_a(1, 1, 3, 32'd1);
        set_b(1, 1, 4, 32'd2);
        run_cycle();
        set_a(0, 0, 0, 0);
        run_cycle();
        set_b(0, 0, 0, 0);
        set_a(1, 0, 3, 32'h0);
        set_b(1, 0, 4, 32'h0);
        run_cycle();
        set_a(0, 0, 0, 0);
        run_cycle();
        chk("cw_a_rv", 32'(obs_a_rv), 32'd1);
        chk("cw_a_data", obs_a_rdata, 32'd1);
        set_b(0, 0, 0, 0);
        run_cycle();
        chk("cw_b_rv", 32'(obs_b_rv), 32'd1);
        chk("cw_b_data", obs_b_rdata, 32'd2);

        // Full clear with A requesting throughout.
        fill_a();
        set_a(1, 0, 0, 32'h0);
        clr = 1'b1;
        run_cycle();
        chk("clr_no_gnt", 32'(obs_a_gnt), 32'd0);
        clr = 1'b0;
        count_clear("clear");
        set_a(0, 0, 0, 0);
        run_cycle();
        read_a("clr_rd0", 0, 32'h0);
        read_a("clr_rd17", 17, 32'h0);
        read_a("clr_rd31", 31, 32'h0);

        // Reset in clear cycle 10.
        fill_a();
        clr = 1'b1;
        run_cycle();
        clr = 1'b0;
        repeat (10) run_cycle();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        run_cycle();
        chk("abort_busy", 32'(obs_busy), 32'd0);
        for (int i = 0; i <= 10; i++) begin
            read_a("abort_rd", i, (i < 10) ? 32'h0 : 32'd11);
        end
        clr = 1'b1;
        run_cycle();
        clr = 1'b0;
        count_clear("reclear");

        // Read granted, then clr in the following cycle.
        do_reset();
        set_a(1, 0, 7, 32'h0);
        run_cycle();
        chk("pend_gnt", 32'(obs_a_gnt), 32'd1);
        set_a(0, 0, 0, 0);
        set_b(1, 0, 9, 32'h0);
        clr = 1'b1;
        run_cycle();
        chk("pend_rv", 32'(obs_a_rv), 32'd1);
        chk("pend_no_gnt", 32'(obs_b_gnt), 32'd0);
        clr = 1'b0;
        for (int i = 0; i < 34 && !obs_b_gnt; i++) run_cycle();
        chk("pend_b_served", 32'(obs_b_gnt), 32'd1);
        set_b(0, 0, 0, 0);
        run_cycle();

        // Random traffic with occasional clr and rst.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            clr = ($urandom_range(0, 59) == 0);
            if (!(a_req && !obs_a_gnt)) begin
                if ($urandom_range(0, 2) != 0)
                    set_a(1, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom);
                else
                    set_a(0, 0, 0, 0);
            end
            if (!(b_req && !obs_b_gnt)) begin
                if ($urandom_range(0, 2) != 0)
                    set_b(1, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom);
                else
                    set_b(0, 0, 0, 0);
            end
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
